board_mem_arbiter: RTL and testbench

Parametrised arbiter that multiplexes N requesting clients (initializer, validator, flipper, display reader, …) onto the single-port gameboard RAM. It replaces the fixed four-way control-line mux with a registered request/grant handshake, selectable fixed-priority or round-robin arbitration, a starvation limit, and per-client read-data-valid tagging matched to the RAM read latency. It sits between the block controllers and `gameboardRAM`.

---
 rtl/board_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_board_mem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/board_mem_arbiter.sv
// Request/grant arbiter that shares the single-port gameboard RAM among N clients,
// with fixed-priority or round-robin selection, a hold limit and read-valid tagging.

module board_mem_arbiter_lane #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 2
) (
    input  logic              grant,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [ADDR_W-1:0] addr_m,
    output logic [DATA_W-1:0] data_m,
    output logic              wren_m,
    output logic              rd
);
    // A non-granted client contributes all zeros, so the top level can OR lanes together.
    assign addr_m = grant ? addr : '0;
    assign data_m = grant ? data : '0;
    assign wren_m = grant & wren;
    assign rd     = grant & ~wren;
endmodule

module board_mem_arbiter #(
    parameter int N_CLIENTS = 4,
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 2,
    parameter int RD_LAT    = 1,
    parameter int RR_MODE   = 1,
    parameter int MAX_HOLD  = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_CLIENTS-1:0]          req,
    input  logic [N_CLIENTS*ADDR_W-1:0]   addr_in,
    input  logic [N_CLIENTS*DATA_W-1:0]   data_in,
    input  logic [N_CLIENTS-1:0]          wren_in,
    output logic [N_CLIENTS-1:0]          grant,
    output logic [ADDR_W-1:0]             addr_out,
    output logic [DATA_W-1:0]             data_out,
    output logic                          wren_out,
    input  logic [DATA_W-1:0]             q_in,
    output logic [DATA_W-1:0]             q_out,
    output logic [N_CLIENTS-1:0]          rvalid
);
    localparam int IDX_W = $clog2(N_CLIENTS);
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    logic [N_CLIENTS-1:0][ADDR_W-1:0] lane_addr;
    logic [N_CLIENTS-1:0][DATA_W-1:0] lane_data;
    logic [N_CLIENTS-1:0]             lane_wren;
    logic [N_CLIENTS-1:0]             lane_rd;

    logic [IDX_W-1:0]     last;
    logic [IDX_W-1:0]     owner_idx;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     sel;
    logic                 pick_vld;
    logic [CNT_W-1:0]     hold_cnt;
    logic                 owner_req;
    logic                 others_req;
    logic                 preempt;
    logic                 keep;
    logic [N_CLIENTS-1:0] cand;

    logic [RD_LAT:1]             vld_pipe;
    logic [RD_LAT:1][IDX_W-1:0]  idx_pipe;
    logic                        rd_push;

    for (genvar i = 0; i < N_CLIENTS; i++) begin : g_lane
        board_mem_arbiter_lane #(
            .ADDR_W(ADDR_W),
            .DATA_W(DATA_W)
        ) u_lane (
            .grant (grant[i]),
            .addr  (addr_in[i*ADDR_W +: ADDR_W]),
            .data  (data_in[i*DATA_W +: DATA_W]),
            .wren  (wren_in[i]),
            .addr_m(lane_addr[i]),
            .data_m(lane_data[i]),
            .wren_m(lane_wren[i]),
            .rd    (lane_rd[i])
        );
        assign rvalid[i] = vld_pipe[RD_LAT] && (idx_pipe[RD_LAT] == IDX_W'(i));
    end

    always_comb begin
        addr_out  = '0;
        data_out  = '0;
        owner_idx = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            addr_out = addr_out | lane_addr[i];
            data_out = data_out | lane_data[i];
            if (grant[i]) owner_idx = IDX_W'(i);
        end
    end

    assign wren_out = |lane_wren;
    assign rd_push  = |lane_rd;
    assign q_out    = q_in;

    // Hold-limit preemption removes the owner from the candidate set so fixed
    // priority cannot hand the grant straight back; in RR it ranks last anyway.
    assign owner_req  = |(req & grant);
    assign others_req = |(req & ~grant);
    assign preempt    = owner_req && (MAX_HOLD != 0) &&
                        (hold_cnt == CNT_W'(MAX_HOLD)) && others_req;
    assign keep       = owner_req && !preempt;
    assign cand       = preempt ? (req & ~grant) : req;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        sel      = '0;
        if (RR_MODE != 0) begin
            for (int k = 1; k <= N_CLIENTS; k++) begin
                sel = IDX_W'((int'(last) + k) % N_CLIENTS);
                if (!pick_vld && cand[sel]) begin
                    pick_vld = 1'b1;
                    pick_idx = sel;
                end
            end
        end else begin
            for (int j = N_CLIENTS - 1; j >= 0; j--) begin
                if (cand[j]) begin
                    pick_vld = 1'b1;
                    pick_idx = IDX_W'(j);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant    <= '0;
            last     <= IDX_W'(N_CLIENTS - 1);
            hold_cnt <= '0;
        end else if (keep) begin
            if ((MAX_HOLD != 0) && (hold_cnt != CNT_W'(MAX_HOLD)))
                hold_cnt <= hold_cnt + CNT_W'(1);
        end else if (pick_vld) begin
            grant    <= N_CLIENTS'(1) << pick_idx;
            last     <= pick_idx;
            hold_cnt <= CNT_W'(1);
        end else begin
            grant    <= '0;
            hold_cnt <= '0;
        end
    end

    // Tags travel with the RAM latency so reads finish to their issuer after hand-over.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            idx_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_push;
            idx_pipe[1] <= owner_idx;
            for (int s = 2; s <= RD_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                idx_pipe[s] <= idx_pipe[s-1];
            end
        end
    end
endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench: three arbiter configurations share one stimulus stream, each with its own RAM.

module tb_board_mem_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [27:0] addr_in;
    logic [7:0]  data_in;
    logic [3:0]  wren_in;

    logic [3:0] grant_a, grant_b, grant_c;
    logic [6:0] addr_out_a, addr_out_b, addr_out_c;
    logic [1:0] data_out_a, data_out_b, data_out_c;
    logic       wren_out_a, wren_out_b, wren_out_c;
    logic [1:0] q_in_a, q_in_b, q_in_c, q1_c;
    logic [1:0] q_out_a, q_out_b, q_out_c;
    logic [3:0] rvalid_a, rvalid_b, rvalid_c;

    logic [1:0] mem_a [128];
    logic [1:0] mem_b [128];
    logic [1:0] mem_c [128];

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    board_mem_arbiter #(.N_CLIENTS(4), .ADDR_W(7), .DATA_W(2), .RD_LAT(1), .RR_MODE(1), .MAX_HOLD(2)) u_a (
        .clock(clock), .reset(reset), .req(req), .addr_in(addr_in), .data_in(data_in), .wren_in(wren_in),
        .grant(grant_a), .addr_out(addr_out_a), .data_out(data_out_a), .wren_out(wren_out_a),
        .q_in(q_in_a), .q_out(q_out_a), .rvalid(rvalid_a));

    board_mem_arbiter #(.N_CLIENTS(4), .ADDR_W(7), .DATA_W(2), .RD_LAT(1), .RR_MODE(0), .MAX_HOLD(0)) u_b (
        .clock(clock), .reset(reset), .req(req), .addr_in(addr_in), .data_in(data_in), .wren_in(wren_in),
        .grant(grant_b), .addr_out(addr_out_b), .data_out(data_out_b), .wren_out(wren_out_b),
        .q_in(q_in_b), .q_out(q_out_b), .rvalid(rvalid_b));

    board_mem_arbiter #(.N_CLIENTS(4), .ADDR_W(7), .DATA_W(2), .RD_LAT(2), .RR_MODE(1), .MAX_HOLD(0)) u_c (
        .clock(clock), .reset(reset), .req(req), .addr_in(addr_in), .data_in(data_in), .wren_in(wren_in),
        .grant(grant_c), .addr_out(addr_out_c), .data_out(data_out_c), .wren_out(wren_out_c),
        .q_in(q_in_c), .q_out(q_out_c), .rvalid(rvalid_c));

    // RAM models: cleared on reset, address 27 preloaded with 2'b01.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 128; i++) begin
                mem_a[i] <= 2'b00;
                mem_b[i] <= 2'b00;
                mem_c[i] <= 2'b00;
            end
            mem_a[27] <= 2'b01;
            mem_b[27] <= 2'b01;
            mem_c[27] <= 2'b01;
            q_in_a <= 2'b00;
            q_in_b <= 2'b00;
            q1_c   <= 2'b00;
            q_in_c <= 2'b00;
        end else begin
            if (wren_out_a) mem_a[addr_out_a] <= data_out_a;
            if (wren_out_b) mem_b[addr_out_b] <= data_out_b;
            if (wren_out_c) mem_c[addr_out_c] <= data_out_c;
            q_in_a <= mem_a[addr_out_a];
            q_in_b <= mem_b[addr_out_b];
            q1_c   <= mem_c[addr_out_c];
            q_in_c <= q1_c;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_rr [9];
        exp_rr = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};

        reset   = 1'b0;
        req     = '0;
        addr_in = '0;
        data_in = '0;
        wren_in = '0;
        #12;
        check("rst_grant",  32'(grant_a), 'h0);
        check("rst_addr",   32'(addr_out_a), 'h0);
        check("rst_data",   32'(data_out_a), 'h0);
        check("rst_wren",   32'(wren_out_a), 'h0);
        check("rst_rvalid", 32'(rvalid_a), 'h0);
        reset = 1'b1;
        tick;
        check("idle_grant", 32'(grant_a), 'h0);

        // single client 2 read of address 27
        addr_in[14 +: 7] = 7'd27;
        req = 4'b0100;
        #1;
        check("rd_pre_grant", 32'(grant_a), 'h0);
        tick;
        check("rd_grant",   32'(grant_a), 'b0100);
        check("rd_addr",    32'(addr_out_a), 'd27);
        check("rd_wren",    32'(wren_out_a), 'h0);
        check("rd_rv_early", 32'(rvalid_a), 'h0);
        req = 4'b0000;
        tick;
        check("rd_rvalid",  32'(rvalid_a), 'b0100);
        check("rd_q",       32'(q_out_a), 'b01);
        check("rd_release", 32'(grant_a), 'h0);
        tick;
        check("rd_rv_done", 32'(rvalid_a), 'h0);

        // all four requesting: RR with hold limit 2 vs fixed priority
        do_reset;
        addr_in = '0;
        req = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            tick;
            check($sformatf("rr_seq%0d", k), 32'(grant_a), 32'(exp_rr[k]));
            check($sformatf("fx_seq%0d", k), 32'(grant_b), 'b0001);
        end
        req = 4'b1110;
        #1;
        check("fx_pre_handover", 32'(grant_b), 'b0001);
        tick;
        check("fx_handover", 32'(grant_b), 'b0010);

        // write by a non-granted client must be blocked
        do_reset;
        addr_in = '0;
        addr_in[7 +: 7] = 7'd5;
        data_in = '0;
        data_in[2 +: 2] = 2'b10;
        wren_in = 4'b0010;
        req = 4'b0011;
        tick;
        check("wr_owner0",   32'(grant_b), 'b0001);
        check("wr_blocked",  32'(wren_out_b), 'h0);
        check("wr_addr0",    32'(addr_out_b), 'h0);
        tick;
        check("wr_mem_keep", 32'(mem_b[5]), 'b00);
        req = 4'b0010;
        tick;
        check("wr_grant1",   32'(grant_b), 'b0010);
        check("wr_wren",     32'(wren_out_b), 'h1);
        check("wr_addr",     32'(addr_out_b), 'd5);
        check("wr_data",     32'(data_out_b), 'b10);
        tick;
        check("wr_mem_new",  32'(mem_b[5]), 'b10);

        // RD_LAT=2: client 3 reads in flight across a hand-over to client 0
        do_reset;
        wren_in = '0;
        addr_in = '0;
        data_in = '0;
        req = 4'b1000;
        tick;
        check("l2_grant3",  32'(grant_c), 'b1000);
        check("l2_rv_c1",   32'(rvalid_c), 'h0);
        tick;
        check("l2_rv_c2",   32'(rvalid_c), 'h0);
        req = 4'b0001;
        tick;
        check("l2_grant0",  32'(grant_c), 'b0001);
        check("l2_rv_c3",   32'(rvalid_c), 'b1000);
        tick;
        check("l2_rv_c4",   32'(rvalid_c), 'b1000);
        tick;
        check("l2_rv_c5",   32'(rvalid_c), 'b0001);

        // reset asserted during a client 1 burst
        do_reset;
        req = 4'b0010;
        tick;
        check("mr_grant",   32'(grant_a), 'b0010);
        tick;
        check("mr_rvalid",  32'(rvalid_a), 'b0010);
        wren_in = 4'b0010;
        #1;
        check("mr_wren_on", 32'(wren_out_a), 'h1);
        reset = 1'b0;
        #1;
        check("mr_grant0",  32'(grant_a), 'h0);
        check("mr_rvalid0", 32'(rvalid_a), 'h0);
        check("mr_wren0",   32'(wren_out_a), 'h0);
        wren_in = '0;
        req = 4'b0110;
        #1;
        reset = 1'b1;
        tick;
        check("mr_rr_first", 32'(grant_a), 'b0010);
        check("mr_fx_first", 32'(grant_b), 'b0010);
        check("mr_rv_clear", 32'(rvalid_a), 'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
